// File: rtl/key_schedule_pkg.sv
// key_schedule_pkg: AES-128 constants, S-box table and GF(2^8) helpers shared by the cipher blocks.
package key_schedule_pkg;
    localparam int NR = 10;
    localparam int NUM_RK = 11;
    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] XTIME_POLY = 8'h1b;
    typedef enum logic {IDLE, RUN} state_e;
    // entry 0 occupies the top byte so the table reads in FIPS-197 order
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
    endfunction
endpackage

// File: rtl/key_schedule_sub_word.sv
// key_schedule_sub_word: AES SubWord, four parallel S-box lookups on a 32-bit word.
module key_schedule_sub_word
    import key_schedule_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);
    for (genvar i = 0; i < 4; i++) begin : g_byte
        assign word_o[8*i +: 8] = sbox(word_i[8*i +: 8]);
    end
endmodule

// File: rtl/key_schedule.sv
// key_schedule: AES-128 key expansion into an 11-slot round-key store, one round key per clock.
module key_schedule #(
    parameter int NR = key_schedule_pkg::NR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         keys_valid,
    output logic         rk_valid,
    output logic [3:0]   rk_idx,
    output logic [127:0] rk_data,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key
);
    import key_schedule_pkg::*;
    state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] rcon_q, rcon_d;
    logic [127:0] slot_q [NUM_RK];
    logic done_q, done_d, kv_q, kv_d;
    logic rk_valid_q;
    logic [3:0] rk_idx_q;
    logic [127:0] rk_data_q, rd_key_q;
    logic wr_en;
    logic [3:0] wr_idx;
    logic [127:0] wr_data, prev, next_key;
    logic [31:0] sw, t, w0, w1, w2, w3;
    assign prev = slot_q[cnt_q - 4'd1];
    key_schedule_sub_word u_sub_word (
        .word_i({prev[23:0], prev[31:24]}),
        .word_o(sw)
    );
    assign t = sw ^ {rcon_q, 24'h0};
    assign w0 = prev[127:96] ^ t;
    assign w1 = prev[95:64] ^ w0;
    assign w2 = prev[63:32] ^ w1;
    assign w3 = prev[31:0] ^ w2;
    assign next_key = {w0, w1, w2, w3};
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        rcon_d = rcon_q;
        done_d = 1'b0;
        kv_d = kv_q;
        wr_en = 1'b0;
        wr_idx = cnt_q;
        wr_data = next_key;
        if (state_q == IDLE) begin
            if (start) begin
                state_d = RUN;
                cnt_d = 4'd1;
                rcon_d = RCON_INIT;
                kv_d = 1'b0;
                wr_en = 1'b1;
                wr_idx = 4'd0;
                wr_data = key_in;
            end
        end else begin
            wr_en = 1'b1;
            cnt_d = cnt_q + 4'd1;
            rcon_d = xtime(rcon_q);
            if (cnt_q == 4'(NR)) begin
                state_d = IDLE;
                done_d = 1'b1;
                kv_d = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            rcon_q <= RCON_INIT;
            done_q <= 1'b0;
            kv_q <= 1'b0;
            rk_valid_q <= 1'b0;
            rk_idx_q <= '0;
            rk_data_q <= '0;
            rd_key_q <= '0;
            for (int k = 0; k < NUM_RK; k++) slot_q[k] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            rcon_q <= rcon_d;
            done_q <= done_d;
            kv_q <= kv_d;
            rk_valid_q <= wr_en;
            // read samples the store before this edge's write lands
            rd_key_q <= (rd_idx > 4'(NR)) ? '0 : slot_q[rd_idx];
            if (wr_en) begin
                slot_q[wr_idx] <= wr_data;
                rk_idx_q <= wr_idx;
                rk_data_q <= wr_data;
            end
        end
    end
    assign busy = (state_q == RUN);
    assign done = done_q;
    assign keys_valid = kv_q;
    assign rk_valid = rk_valid_q;
    assign rk_idx = rk_idx_q;
    assign rk_data = rk_data_q;
    assign rd_key = rd_key_q;
endmodule

// File: tb/tb_key_schedule.sv
// tb_key_schedule: directed bench with a round-key stream scoreboard against FIPS-197 vectors.
module tb_key_schedule;
    logic clk = 1'b0;
    logic rst, start, busy, done, keys_valid, rk_valid;
    logic [127:0] key_in, rk_data, rd_key;
    logic [3:0] rk_idx, rd_idx;
    typedef struct {
        logic [3:0] idx;
        logic [127:0] data;
        bit chk;
    } rk_t;
    rk_t sb[$];
    int total = 0;
    int bad = 0;
    int e, b;
    localparam logic [127:0] ZS1 = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZS10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    logic [127:0] k1s [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    key_schedule dut (
        .clk(clk), .rst(rst), .start(start), .key_in(key_in),
        .busy(busy), .done(done), .keys_valid(keys_valid),
        .rk_valid(rk_valid), .rk_idx(rk_idx), .rk_data(rk_data),
        .rd_idx(rd_idx), .rd_key(rd_key)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic push_k1();
        for (int i = 0; i < 11; i++) sb.push_back('{4'(i), k1s[i], 1'b1});
    endtask
    task automatic push_zero();
        for (int i = 0; i < 11; i++)
            sb.push_back('{4'(i), (i == 1) ? ZS1 : (i == 10) ? ZS10 : 128'h0, (i <= 1) || (i == 10)});
    endtask
    task automatic tick();
        rk_t x;
        @(posedge clk);
        #1;
        check("rk_valid", 128'(rk_valid), 128'(sb.size() != 0));
        if (rk_valid && sb.size() != 0) begin
            x = sb.pop_front();
            check("rk_idx", 128'(rk_idx), 128'(x.idx));
            if (x.chk) check("rk_data", rk_data, x.data);
        end
    endtask
    task automatic run(input int pulse_at, output int edges, output int busy_cnt);
        edges = 0;
        busy_cnt = 0;
        do begin
            tick();
            edges++;
            busy_cnt += int'(busy);
            start = (edges == pulse_at);
            if (edges == pulse_at) key_in = {4{$urandom}};
        end while (!done && edges < 40);
    endtask
    initial begin
        rst = 1'b1;
        start = 1'b0;
        key_in = '0;
        rd_idx = '0;
        #12;
        check("rst_busy", 128'(busy), 0);
        check("rst_done", 128'(done), 0);
        check("rst_kv", 128'(keys_valid), 0);
        check("rst_rk_data", rk_data, 0);
        check("rst_rd_key", rd_key, 0);
        rst = 1'b0;
        tick();
        // K1 with a foreign start and key_in change mid-run
        key_in = k1s[0];
        start = 1'b1;
        push_k1();
        run(5, e, b);
        check("k1_latency", 128'(e), 11);
        check("k1_busy_cycles", 128'(b), 10);
        check("k1_kv", 128'(keys_valid), 1);
        rd_idx = 4'd1;
        tick();
        check("k1_done_single", 128'(done), 0);
        check("k1_rd1", rd_key, k1s[1]);
        rd_idx = 4'd10;
        tick();
        check("k1_rd10", rd_key, k1s[10]);
        rd_idx = 4'd15;
        tick();
        check("rd_oob", rd_key, 0);
        // zero key; slot 0 read on the start edge returns the old contents
        key_in = '0;
        start = 1'b1;
        rd_idx = 4'd0;
        push_zero();
        tick();
        start = 1'b0;
        check("rd_same_edge", rd_key, k1s[0]);
        check("z_kv_clear", 128'(keys_valid), 0);
        check("z_busy", 128'(busy), 1);
        run(0, e, b);
        check("z_latency", 128'(e), 10);
        rd_idx = 4'd1;
        tick();
        check("z_rd1", rd_key, ZS1);
        rd_idx = 4'd10;
        tick();
        check("z_rd10", rd_key, ZS10);
        // reset in the middle of an expansion
        key_in = k1s[0];
        start = 1'b1;
        push_k1();
        tick();
        start = 1'b0;
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        sb.delete();
        check("mid_rst_busy", 128'(busy), 0);
        check("mid_rst_done", 128'(done), 0);
        check("mid_rst_kv", 128'(keys_valid), 0);
        check("mid_rst_rk_valid", 128'(rk_valid), 0);
        check("mid_rst_rk_idx", 128'(rk_idx), 0);
        check("mid_rst_rk_data", rk_data, 0);
        check("mid_rst_rd_key", rd_key, 0);
        rd_idx = 4'd5;
        #3 rst = 1'b0;
        tick();
        check("rst_slot5_clear", rd_key, 0);
        start = 1'b1;
        push_k1();
        run(0, e, b);
        check("post_rst_latency", 128'(e), 11);
        rd_idx = 4'd10;
        tick();
        check("post_rst_rd10", rd_key, k1s[10]);
        // back-to-back: start held high through done
        key_in = '0;
        start = 1'b1;
        push_zero();
        e = 0;
        do begin
            tick();
            e++;
        end while (!done && e < 40);
        check("b2b_first_latency", 128'(e), 11);
        key_in = k1s[0];
        push_k1();
        tick();
        start = 1'b0;
        check("b2b_kv_drop", 128'(keys_valid), 0);
        check("b2b_restart_busy", 128'(busy), 1);
        run(0, e, b);
        check("b2b_second_latency", 128'(e), 10);
        check("b2b_kv", 128'(keys_valid), 1);
        rd_idx = 4'd15;
        tick();
        check("b2b_rd15", rd_key, 0);
        rd_idx = 4'd10;
        tick();
        check("b2b_rd10", rd_key, k1s[10]);
        check("sb_drained", 128'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
